vx_decode_issue: RTL and testbench
==================================

VX_DECODE_ISSUE -- requirements
Module: VX_decode_issue

Interface
REQ-001 SHALL have parameter NW, default 8, number of warps (power of two, >=2); WB = log2(NW).
REQ-002 SHALL have parameter NT, default 4, threads per warp.
REQ-003 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have in_valid  input  1, in_ready  output  1  fetch handshake.
REQ-006 SHALL have in_instruction  input  32, in_curr_PC  input  32, in_warp_num  input  WB, in_thread_mask  input  NT.
REQ-007 SHALL have wb_valid  input  1, wb_warp_num  input  WB, wb_rd  input  5  writeback retire.
REQ-008 SHALL have flush_valid  input  1, flush_warp_num  input  WB  warp flush.
REQ-009 SHALL have out_valid  output  1, out_ready  input  1  issue handshake.
REQ-010 SHALL have out_PC  32, out_warp_num  WB, out_thread_mask  NT, out_rd/out_rs1/out_rs2  5 each, out_use_rs1  1, out_use_rs2  1, out_wb  2, out_itype_immed  32 (all outputs, registered).
REQ-011 SHALL have stall_count  output  32  hazard stall cycle counter.

Function
REQ-012 SHALL decode opcodes R=0110011, L=0000011, ALU=0010011, S=0100011, B=1100011, JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111, SYS=1110011, GPGPU=1101011; rd=[11:7], rs1=[19:15], rs2=[24:20], func3=[14:12].
REQ-013 SHALL set wb: 3 (JAL) for JAL/JALR/GPGPU func3=6/SYS func3=0; 2 (MEM) for L; 1 (ALU) for R/ALU/LUI/AUIPC/SYS func3!=0; else 0.
REQ-014 SHALL set use_rs1 for R,L,ALU,S,B,JALR,GPGPU and SYS with func3 in {1,2,3}; use_rs2 for R,S,B and GPGPU func3 in {0,6}.
REQ-015 SHALL form immediate: ALU shift (func3 1/5) zero-extended [24:20]; ALU/L/JALR sign-extended [31:20]; S sign-extended {[31:25],[11:7]}; B sign-extended {[31],[7],[30:25],[11:8],0}; JAL sign-extended {[31],[19:12],[20],[30:21],0}; LUI/AUIPC {[31:12],12'h0}; else 0.
REQ-016 SHALL keep a scoreboard of NW x 32 pending bits; bit 0 of each warp never set.
REQ-017 SHALL define writes = (wb!=0) && rd!=0; hazard = (use_rs1 && pend[w][rs1]) || (use_rs2 && pend[w][rs2]) || (writes && pend[w][rd]), w=in_warp_num, using registered pending state (no writeback bypass).
REQ-018 SHALL drive in_ready = !reset && !hazard && !(flush_valid && flush_warp_num==in_warp_num) && (!out_valid || out_ready).
REQ-019 SHALL on accept (in_valid && in_ready) load all output fields and assert out_valid next cycle; set pend[w][rd] if writes.
REQ-020 SHALL deassert out_valid when out_ready is high and no accept occurs; outputs hold while out_valid && !out_ready.
REQ-021 SHALL clear pend[wb_warp_num][wb_rd] next cycle on wb_valid; wb_rd=0 ignored; in same cycle a set on the same bit wins.
REQ-022 SHALL on flush_valid clear all 32 pending bits of flush_warp_num, and drop a held output (out_valid=0 next cycle) whose out_warp_num matches; flush clear takes priority over same-cycle set for that warp.
REQ-023 SHALL increment stall_count each cycle in_valid && !in_ready && !reset, saturating at 32'hFFFFFFFF.
REQ-024 SHALL give one-cycle decode-to-issue latency and sustain one instruction per cycle with no hazards and out_ready high.

Reset
REQ-025 SHALL on reset clear all pending bits, out_valid, all output fields, and stall_count to 0; in_ready 0 while reset high.
REQ-026 SHALL discard any in-flight output and ignore wb/flush inputs during reset.

Verification
REQ-027 Back-to-back: warp 0 "addi x5,x0,1" then warp 1 "add x6,x5,x5", out_ready=1 -> both issue on consecutive cycles, out_wb=1, immed=1.
REQ-028 RAW stall: warp 0 "lw x5,0(x1)" then "add x6,x5,x2" -> in_ready=0 until wb_valid(warp 0, rd 5); issue one cycle after wb; stall_count equals stalled cycles.
REQ-029 Backpressure: out_ready=0 for 3 cycles with valid output -> outputs stable, in_ready=0, no pending change.
REQ-030 Flush: pend[2][7] set, output held for warp 2, flush_valid warp 2 -> out_valid=0 and pend[2] all zero next cycle; warp 3 unaffected.
REQ-031 Reset mid-operation: pending bits set, out_valid=1, assert reset one cycle -> all outputs 0, stall_count 0, then "jal x1,8" issues with out_wb=3, out_itype_immed=8.
REQ-032 Saturation: force stall_count to 32'hFFFFFFFE via 2 stall cycles after preload -> holds 32'hFFFFFFFF.

Source files
------------

// File: rtl/vx_decode_issue.sv
// vx_decode_issue
//   Decode and issue stage for a multi-warp GPGPU pipeline. It decodes one
//   fetched instruction per cycle and tracks in-flight destination registers
//   per warp in a scoreboard. Instructions with a RAW/WAW hazard are held off
//   at the fetch handshake. Decoded fields are registered with one cycle of
//   latency and held under issue backpressure.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : fetch handshake
//   in_instruction        : 32-bit instruction word
//   in_curr_PC            : PC of the instruction
//   in_warp_num           : issuing warp
//   in_thread_mask        : active threads of the warp
//   wb_valid/_warp_num/_rd: writeback retire, clears one scoreboard bit
//   flush_valid/_warp_num : drops all pending state and any held output of a warp
//   out_valid / out_ready : issue handshake
//   out_*                 : registered decoded fields
//   stall_count           : saturating count of cycles fetch was held off
module vx_decode_issue #(
  parameter int NW = 8,
  parameter int NT = 4,
  localparam int WB = $clog2(NW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instruction,
  input  logic [31:0]   in_curr_PC,
  input  logic [WB-1:0] in_warp_num,
  input  logic [NT-1:0] in_thread_mask,
  input  logic          wb_valid,
  input  logic [WB-1:0] wb_warp_num,
  input  logic [4:0]    wb_rd,
  input  logic          flush_valid,
  input  logic [WB-1:0] flush_warp_num,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_PC,
  output logic [WB-1:0] out_warp_num,
  output logic [NT-1:0] out_thread_mask,
  output logic [4:0]    out_rd,
  output logic [4:0]    out_rs1,
  output logic [4:0]    out_rs2,
  output logic          out_use_rs1,
  output logic          out_use_rs2,
  output logic [1:0]    out_wb,
  output logic [31:0]   out_itype_immed,
  output logic [31:0]   stall_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_ALU   = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_GPGPU = 7'b1101011;

  logic [31:0]   r_pending [NW];
  logic [31:0]   w_pendNext [NW];
  logic          r_outValid;
  logic [31:0]   r_outPC;
  logic [WB-1:0] r_outWarpNum;
  logic [NT-1:0] r_outThreadMask;
  logic [4:0]    r_outRd;
  logic [4:0]    r_outRs1;
  logic [4:0]    r_outRs2;
  logic          r_outUseRs1;
  logic          r_outUseRs2;
  logic [1:0]    r_outWb;
  logic [31:0]   r_outImmed;
  logic [31:0]   r_stallCount;
  logic [31:0]   w_stallNext;

  logic [6:0]    w_opcode;
  logic [2:0]    w_func3;
  logic [4:0]    w_rd;
  logic [4:0]    w_rs1;
  logic [4:0]    w_rs2;
  logic [1:0]    w_wb;
  logic          w_useRs1;
  logic          w_useRs2;
  logic [31:0]   w_immed;
  logic          w_writes;
  logic [31:0]   w_pendCur;
  logic          w_hazard;
  logic          w_flushHit;
  logic          w_accept;
  logic          w_stall;

  // Field extraction plus the writeback class, register usage and immediate
  // for each opcode. Shift-immediates keep only the shamt, zero-extended.
  always_comb begin
    w_opcode = in_instruction[6:0];
    w_func3  = in_instruction[14:12];
    w_rd     = in_instruction[11:7];
    w_rs1    = in_instruction[19:15];
    w_rs2    = in_instruction[24:20];
    w_wb     = 2'd0;
    w_useRs1 = 1'b0;
    w_useRs2 = 1'b0;
    w_immed  = 32'h0;
    case (w_opcode)
      OP_R: begin
        w_wb     = 2'd1;
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
      end
      OP_L: begin
        w_wb     = 2'd2;
        w_useRs1 = 1'b1;
        w_immed  = {{20{in_instruction[31]}}, in_instruction[31:20]};
      end
      OP_ALU: begin
        w_wb     = 2'd1;
        w_useRs1 = 1'b1;
        if (w_func3 == 3'd1 || w_func3 == 3'd5)
          w_immed = {27'h0, in_instruction[24:20]};
        else
          w_immed = {{20{in_instruction[31]}}, in_instruction[31:20]};
      end
      OP_S: begin
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        w_immed  = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
      end
      OP_B: begin
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        w_immed  = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                    in_instruction[30:25], in_instruction[11:8], 1'b0};
      end
      OP_JAL: begin
        w_wb    = 2'd3;
        w_immed = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                   in_instruction[20], in_instruction[30:21], 1'b0};
      end
      OP_JALR: begin
        w_wb     = 2'd3;
        w_useRs1 = 1'b1;
        w_immed  = {{20{in_instruction[31]}}, in_instruction[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        w_wb    = 2'd1;
        w_immed = {in_instruction[31:12], 12'h0};
      end
      OP_SYS: begin
        w_wb     = (w_func3 == 3'd0) ? 2'd3 : 2'd1;
        w_useRs1 = (w_func3 == 3'd1) || (w_func3 == 3'd2) || (w_func3 == 3'd3);
      end
      OP_GPGPU: begin
        w_wb     = (w_func3 == 3'd6) ? 2'd3 : 2'd0;
        w_useRs1 = 1'b1;
        w_useRs2 = (w_func3 == 3'd0) || (w_func3 == 3'd6);
      end
      default: begin
        w_wb = 2'd0;
      end
    endcase
  end

  // Hazard check against registered scoreboard state only; a writeback in
  // the same cycle does not unblock the instruction until the next cycle.
  always_comb begin
    w_writes   = (w_wb != 2'd0) && (w_rd != 5'd0);
    w_pendCur  = r_pending[in_warp_num];
    w_hazard   = (w_useRs1 && w_pendCur[w_rs1]) ||
                 (w_useRs2 && w_pendCur[w_rs2]) ||
                 (w_writes && w_pendCur[w_rd]);
    w_flushHit = flush_valid && (flush_warp_num == in_warp_num);
    in_ready   = !reset && !w_hazard && !w_flushHit && (!r_outValid || out_ready);
    w_accept   = in_valid && in_ready;
    w_stall    = in_valid && !in_ready && !reset;
    w_stallNext = (w_stall && r_stallCount != 32'hFFFF_FFFF) ? r_stallCount + 32'd1
                                                             : r_stallCount;
  end

  // Scoreboard next state: retire clear, then accept set (set wins on the
  // same bit), then flush wipes the whole warp above everything else.
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      w_pendNext[w] = r_pending[w];
      if (wb_valid && wb_warp_num == WB'(w) && wb_rd != 5'd0)
        w_pendNext[w][wb_rd] = 1'b0;
      if (w_accept && w_writes && in_warp_num == WB'(w))
        w_pendNext[w][w_rd] = 1'b1;
      if (flush_valid && flush_warp_num == WB'(w))
        w_pendNext[w] = 32'h0;
    end
  end

  // Scoreboard register; reset also masks any writeback or flush input.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (reset)
        r_pending[w] <= 32'h0;
      else
        r_pending[w] <= w_pendNext[w];
    end
  end

  // Issue register: load on accept, drop a held entry of a flushed warp,
  // retire on out_ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outValid      <= 1'b0;
      r_outPC         <= 32'h0;
      r_outWarpNum    <= '0;
      r_outThreadMask <= '0;
      r_outRd         <= 5'd0;
      r_outRs1        <= 5'd0;
      r_outRs2        <= 5'd0;
      r_outUseRs1     <= 1'b0;
      r_outUseRs2     <= 1'b0;
      r_outWb         <= 2'd0;
      r_outImmed      <= 32'h0;
    end else if (w_accept) begin
      r_outValid      <= 1'b1;
      r_outPC         <= in_curr_PC;
      r_outWarpNum    <= in_warp_num;
      r_outThreadMask <= in_thread_mask;
      r_outRd         <= w_rd;
      r_outRs1        <= w_rs1;
      r_outRs2        <= w_rs2;
      r_outUseRs1     <= w_useRs1;
      r_outUseRs2     <= w_useRs2;
      r_outWb         <= w_wb;
      r_outImmed      <= w_immed;
    end else if (flush_valid && r_outValid && flush_warp_num == r_outWarpNum) begin
      r_outValid <= 1'b0;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Stall counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset)
      r_stallCount <= 32'h0;
    else
      r_stallCount <= w_stallNext;
  end

  assign out_valid       = r_outValid;
  assign out_PC          = r_outPC;
  assign out_warp_num    = r_outWarpNum;
  assign out_thread_mask = r_outThreadMask;
  assign out_rd          = r_outRd;
  assign out_rs1         = r_outRs1;
  assign out_rs2         = r_outRs2;
  assign out_use_rs1     = r_outUseRs1;
  assign out_use_rs2     = r_outUseRs2;
  assign out_wb          = r_outWb;
  assign out_itype_immed = r_outImmed;
  assign stall_count     = r_stallCount;

endmodule

// File: tb/tb_vx_decode_issue.sv
// tb_vx_decode_issue
//   Self-checking bench for vx_decode_issue. Each accepted instruction pushes
//   its hand-decoded expected fields onto a queue; a negedge monitor pops and
//   compares whenever the DUT hands an instruction over. Inputs change 1ns
//   after the rising edge, outputs are sampled on the falling edge.
module tb_vx_decode_issue;

  localparam int NW = 8;
  localparam int NT = 4;
  localparam int WB = 3;

  typedef struct {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [WB-1:0] warp;
    logic [NT-1:0] mask;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          u1;
    logic          u2;
    logic [1:0]    wb;
    logic [31:0]   imm;
  } stim_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instruction;
  logic [31:0]   in_curr_PC;
  logic [WB-1:0] in_warp_num;
  logic [NT-1:0] in_thread_mask;
  logic          wb_valid;
  logic [WB-1:0] wb_warp_num;
  logic [4:0]    wb_rd;
  logic          flush_valid;
  logic [WB-1:0] flush_warp_num;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_PC;
  logic [WB-1:0] out_warp_num;
  logic [NT-1:0] out_thread_mask;
  logic [4:0]    out_rd;
  logic [4:0]    out_rs1;
  logic [4:0]    out_rs2;
  logic          out_use_rs1;
  logic          out_use_rs2;
  logic [1:0]    out_wb;
  logic [31:0]   out_itype_immed;
  logic [31:0]   stall_count;

  int    errors = 0;
  int    checks = 0;
  stim_t expQ[$];
  stim_t monItem;
  stim_t table7[9];

  vx_decode_issue #(.NW(NW), .NT(NT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_curr_PC(in_curr_PC),
    .in_warp_num(in_warp_num), .in_thread_mask(in_thread_mask),
    .wb_valid(wb_valid), .wb_warp_num(wb_warp_num), .wb_rd(wb_rd),
    .flush_valid(flush_valid), .flush_warp_num(flush_warp_num),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_PC(out_PC), .out_warp_num(out_warp_num), .out_thread_mask(out_thread_mask),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2),
    .out_wb(out_wb), .out_itype_immed(out_itype_immed),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic stim_t mk(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [WB-1:0] warp, input logic [NT-1:0] mask,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [1:0] wb,
                               input logic [31:0] imm);
    stim_t s;
    s.instr = instr; s.pc = pc; s.warp = warp; s.mask = mask;
    s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.wb = wb; s.imm = imm;
    return s;
  endfunction

  // Presents one instruction (called 1ns after a rising edge) and waits up
  // to maxWait extra cycles for in_ready; returns 1ns after the accepting
  // edge (or after giving up) with in_valid dropped.
  task automatic applyStimulus(input stim_t s, input int maxWait,
                               output int waited, output bit accepted);
    waited = 0;
    in_valid = 1'b1;
    in_instruction = s.instr;
    in_curr_PC = s.pc;
    in_warp_num = s.warp;
    in_thread_mask = s.mask;
    @(negedge clk);
    while (!in_ready && waited < maxWait) begin
      @(negedge clk);
      waited++;
    end
    accepted = in_ready;
    if (accepted) expQ.push_back(s);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulseWb(input int delay, input logic [WB-1:0] warp, input logic [4:0] rd);
    repeat (delay) @(posedge clk);
    #1;
    wb_valid = 1'b1; wb_warp_num = warp; wb_rd = rd;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainQueue", expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake pops and compares one entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedIssue", 1, 0);
      end else begin
        monItem = expQ.pop_front();
        checkOutput("outPC", out_PC, monItem.pc);
        checkOutput("outWarp", 32'(out_warp_num), 32'(monItem.warp));
        checkOutput("outMask", 32'(out_thread_mask), 32'(monItem.mask));
        checkOutput("outRd", 32'(out_rd), 32'(monItem.rd));
        checkOutput("outRs1", 32'(out_rs1), 32'(monItem.rs1));
        checkOutput("outRs2", 32'(out_rs2), 32'(monItem.rs2));
        checkOutput("outUseRs1", 32'(out_use_rs1), 32'(monItem.u1));
        checkOutput("outUseRs2", 32'(out_use_rs2), 32'(monItem.u2));
        checkOutput("outWb", 32'(out_wb), 32'(monItem.wb));
        checkOutput("outImmed", out_itype_immed, monItem.imm);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  w;
    bit  acc;
    stim_t sAddi, sAddWarp1, sLw, sAddRaw, sAddiBp, sAddi8, sAddi7, sAdd9, sAdd10, sJal, sAddi11;

    sAddi     = mk(32'h00100293, 32'h0000_0100, 3'd0, 4'hF, 5'd5, 5'd0, 5'd1, 1, 0, 2'd1, 32'd1);
    sAddWarp1 = mk(32'h00528333, 32'h0000_0104, 3'd1, 4'h3, 5'd6, 5'd5, 5'd5, 1, 1, 2'd1, 32'd0);
    sLw       = mk(32'h0000A283, 32'h0000_0200, 3'd0, 4'hF, 5'd5, 5'd1, 5'd0, 1, 0, 2'd2, 32'd0);
    sAddRaw   = mk(32'h00228333, 32'h0000_0204, 3'd0, 4'hE, 5'd6, 5'd5, 5'd2, 1, 1, 2'd1, 32'd0);
    sAddiBp   = mk(32'h00300493, 32'h0000_0300, 3'd1, 4'h5, 5'd9, 5'd0, 5'd3, 1, 0, 2'd1, 32'd3);
    sAddi8    = mk(32'h00200413, 32'h0000_0400, 3'd3, 4'h9, 5'd8, 5'd0, 5'd2, 1, 0, 2'd1, 32'd2);
    sAddi7    = mk(32'h00500393, 32'h0000_0404, 3'd2, 4'h7, 5'd7, 5'd0, 5'd5, 1, 0, 2'd1, 32'd5);
    sAdd9     = mk(32'h007384B3, 32'h0000_0408, 3'd2, 4'h7, 5'd9, 5'd7, 5'd7, 1, 1, 2'd1, 32'd0);
    sAdd10    = mk(32'h00040533, 32'h0000_040C, 3'd3, 4'h9, 5'd10, 5'd8, 5'd0, 1, 1, 2'd1, 32'd0);
    sJal      = mk(32'h008000EF, 32'h0000_0500, 3'd0, 4'hF, 5'd1, 5'd0, 5'd8, 0, 0, 2'd3, 32'd8);
    sAddi11   = mk(32'h00008593, 32'h0000_0504, 3'd0, 4'hF, 5'd11, 5'd1, 5'd0, 1, 0, 2'd1, 32'd0);

    table7[0] = mk(32'hFE312E23, 32'h0000_1000, 3'd0, 4'h1, 5'd28, 5'd2, 5'd3, 1, 1, 2'd0, 32'hFFFF_FFFC);
    table7[1] = mk(32'hFE208CE3, 32'h0000_1004, 3'd5, 4'h2, 5'd25, 5'd1, 5'd2, 1, 1, 2'd0, 32'hFFFF_FFF8);
    table7[2] = mk(32'h12345637, 32'h0000_1008, 3'd6, 4'h4, 5'd12, 5'd8, 5'd3, 0, 0, 2'd1, 32'h1234_5000);
    table7[3] = mk(32'hFFF081E7, 32'h0000_100C, 3'd7, 4'h8, 5'd3, 5'd1, 5'd31, 1, 0, 2'd3, 32'hFFFF_FFFF);
    table7[4] = mk(32'h41F25213, 32'h0000_1010, 3'd4, 4'hA, 5'd4, 5'd4, 5'd31, 1, 0, 2'd1, 32'd31);
    table7[5] = mk(32'hC00026F3, 32'h0000_1014, 3'd3, 4'hC, 5'd13, 5'd0, 5'd0, 1, 0, 2'd1, 32'd0);
    table7[6] = mk(32'h0062E76B, 32'h0000_1018, 3'd2, 4'h6, 5'd14, 5'd5, 5'd6, 1, 1, 2'd3, 32'd0);
    table7[7] = mk(32'hFFFFF797, 32'h0000_101C, 3'd1, 4'h3, 5'd15, 5'd31, 5'd31, 0, 0, 2'd1, 32'hFFFF_F000);
    table7[8] = mk(32'h00000073, 32'h0000_1020, 3'd0, 4'hF, 5'd0, 5'd0, 5'd0, 0, 0, 2'd3, 32'd0);

    reset = 1'b1; in_valid = 1'b1; in_instruction = sAddi.instr; in_curr_PC = 32'h0;
    in_warp_num = '0; in_thread_mask = '0; wb_valid = 1'b0; wb_warp_num = '0; wb_rd = '0;
    flush_valid = 1'b0; flush_warp_num = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetInReady", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("resetOutValid", 32'(out_valid), 0);
    checkOutput("resetStall", stall_count, 0);
    checkOutput("resetOutPC", out_PC, 0);
    @(posedge clk); #1;

    // Back-to-back issue on two warps
    applyStimulus(sAddi, 5, w, acc);
    checkOutput("b2bFirstWait", w, 0);
    applyStimulus(sAddWarp1, 5, w, acc);
    checkOutput("b2bSecondWait", w, 0);
    waitDrain();
    doReset();

    // RAW stall released by writeback
    applyStimulus(sLw, 5, w, acc);
    fork
      applyStimulus(sAddRaw, 20, w, acc);
      pulseWb(3, 3'd0, 5'd5);
    join
    checkOutput("rawAccepted", 32'(acc), 1);
    checkOutput("rawStallCycles", w, 4);
    @(negedge clk);
    checkOutput("rawStallCount", stall_count, 4);
    waitDrain();
    doReset();

    // Backpressure holds the output and blocks fetch
    out_ready = 1'b0;
    applyStimulus(sAddi, 5, w, acc);
    fork
      applyStimulus(sAddiBp, 10, w, acc);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("bpOutValid", 32'(out_valid), 1);
          checkOutput("bpOutPC", out_PC, 32'h0000_0100);
          checkOutput("bpOutRd", 32'(out_rd), 5);
          checkOutput("bpInReady", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    checkOutput("bpStallCycles", w, 3);
    @(negedge clk);
    checkOutput("bpStallCount", stall_count, 3);
    waitDrain();
    doReset();

    // Flush drops warp 2 pending bits and held output, warp 3 untouched
    applyStimulus(sAddi8, 5, w, acc);
    waitDrain();
    out_ready = 1'b0;
    applyStimulus(sAddi7, 5, w, acc);
    flush_valid = 1'b1; flush_warp_num = 3'd2;
    void'(expQ.pop_back());
    @(posedge clk); #1;
    flush_valid = 1'b0;
    @(negedge clk);
    checkOutput("flushOutValid", 32'(out_valid), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(sAdd9, 5, w, acc);
    checkOutput("flushWarp2Wait", w, 0);
    fork
      applyStimulus(sAdd10, 20, w, acc);
      pulseWb(2, 3'd3, 5'd8);
    join
    checkOutput("flushWarp3Stall", w, 3);
    waitDrain();
    doReset();

    // Reset in the middle of activity
    out_ready = 1'b0;
    applyStimulus(sLw, 5, w, acc);
    applyStimulus(sAddRaw, 2, w, acc);
    checkOutput("preResetAccepted", 32'(acc), 0);
    @(negedge clk);
    checkOutput("preResetStall", stall_count, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    expQ.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midResetOutValid", 32'(out_valid), 0);
    checkOutput("midResetOutPC", out_PC, 0);
    checkOutput("midResetOutRd", 32'(out_rd), 0);
    checkOutput("midResetOutWb", 32'(out_wb), 0);
    checkOutput("midResetImmed", out_itype_immed, 0);
    checkOutput("midResetMask", 32'(out_thread_mask), 0);
    checkOutput("midResetStall", stall_count, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(sJal, 5, w, acc);
    checkOutput("jalWait", w, 0);
    applyStimulus(sAddRaw, 5, w, acc);
    checkOutput("pendClearedWait", w, 0);
    waitDrain();

    // Stall counter saturation (warp 0 x1 still pending from jal)
    force dut.r_stallCount = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.r_stallCount;
    @(negedge clk);
    checkOutput("satPreload", stall_count, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    applyStimulus(sAddi11, 1, w, acc);
    checkOutput("satAccepted", 32'(acc), 0);
    @(negedge clk);
    checkOutput("satHold", stall_count, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    doReset();

    // Decode coverage at full throughput across warps
    for (int i = 0; i < 9; i++) begin
      applyStimulus(table7[i], 3, w, acc);
      checkOutput("tableWait", w, 0);
    end
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
